// File: rtl/mem_access.sv
`timescale 1ns/1ps
// mem_access: MEM-stage data-access unit. Runs one req/ack bus transaction
// per load/store, steers byte lanes, extends load data, stalls the pipeline
// until the access retires and reports misaligned accesses and bus timeouts.

package mem_access_pkg;
  typedef enum logic [3:0] {
    OP_NOP,
    OP_ALU,
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU,
    OP_LW,
    OP_SB,
    OP_SH,
    OP_SW
  } Oper_t;
endpackage

module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  Oper_t       oper_i,
  input  logic [31:0] mem_oper_addr_i,
  input  logic [31:0] mem_oper_data_i,
  input  logic        wreg_write_i,
  input  logic [4:0]  wreg_addr_i,
  input  logic [31:0] wreg_data_i,
  input  logic        flush,
  output logic        data_req,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_ack,
  input  logic [31:0] data_rdata,
  output logic        wreg_write_o,
  output logic [4:0]  wreg_addr_o,
  output logic [31:0] wreg_data_o,
  output logic        stallreq,
  output logic        addr_err_load,
  output logic        addr_err_store,
  output logic        bus_err,
  output logic [31:0] bad_vaddr
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Timeout is disabled when TIMEOUT_CYCLES is 0; otherwise the counter
  // reaching TMO_LAST on a BUSY cycle without ack ends the transaction.
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       result;
  logic              timed_out;
  logic              squash_q;
  logic              load_q;

  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic [1:0]        acc_size;
  logic              misaligned;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_val;
  logic              start;
  logic              acked;
  logic              tmo;
  logic              finish;

  // Decode the operation: access kind, size (0=byte,1=half,2=word),
  // alignment check, byte enables and lane-replicated store data.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    acc_size  = 2'd0;
    case (oper_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; acc_size = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; acc_size = 2'd1; end
      OP_LW:         begin is_load  = 1'b1; acc_size = 2'd2; end
      OP_SB:         begin is_store = 1'b1; acc_size = 2'd0; end
      OP_SH:         begin is_store = 1'b1; acc_size = 2'd1; end
      OP_SW:         begin is_store = 1'b1; acc_size = 2'd2; end
      default:       begin is_load  = 1'b0; is_store = 1'b0; end
    endcase
    is_mem = is_load | is_store;

    case (acc_size)
      2'd1:    misaligned = is_mem & mem_oper_addr_i[0];
      2'd2:    misaligned = is_mem & (|mem_oper_addr_i[1:0]);
      default: misaligned = 1'b0;
    endcase

    case (acc_size)
      2'd0:    req_be = 4'b0001 << mem_oper_addr_i[1:0];
      2'd1:    req_be = mem_oper_addr_i[1] ? 4'b1100 : 4'b0011;
      default: req_be = 4'b1111;
    endcase

    case (acc_size)
      2'd0:    req_wdata = {4{mem_oper_data_i[7:0]}};
      2'd1:    req_wdata = {2{mem_oper_data_i[15:0]}};
      default: req_wdata = mem_oper_data_i;
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    case (mem_oper_addr_i[1:0])
      2'd0:    ld_byte = data_rdata[7:0];
      2'd1:    ld_byte = data_rdata[15:8];
      2'd2:    ld_byte = data_rdata[23:16];
      default: ld_byte = data_rdata[31:24];
    endcase
    ld_half = mem_oper_addr_i[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (oper_i)
      OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_val = {24'd0, ld_byte};
      OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_val = {16'd0, ld_half};
      default: load_val = data_rdata;
    endcase
  end

  // Transaction events: a new access starts, the bus acks, or the wait times out.
  always_comb begin
    start  = (state == IDLE) && is_mem && !misaligned && !flush;
    acked  = (state == BUSY) && data_req && data_ack;
    tmo    = (state == BUSY) && !acked && TMO_EN && (cnt == TMO_LAST);
    finish = acked || tmo;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a squashed access skips DONE so nothing retires.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = BUSY;
      BUSY: if (finish) state_nx = (squash_q || flush) ? IDLE : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus request registers, timeout counter, load result and status latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_req   <= 1'b0;
      data_we    <= 1'b0;
      data_be    <= 4'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
      cnt        <= '0;
      result     <= 32'd0;
      timed_out  <= 1'b0;
      squash_q   <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt       <= '0;
          timed_out <= 1'b0;
          squash_q  <= 1'b0;
          if (start) begin
            data_req   <= 1'b1;
            data_we    <= is_store;
            data_be    <= req_be;
            data_addr  <= {mem_oper_addr_i[31:2], 2'b00};
            data_wdata <= req_wdata;
            load_q     <= is_load;
          end
        end
        BUSY: begin
          if (flush) squash_q <= 1'b1;
          if (finish) begin
            data_req <= 1'b0;
            data_we  <= 1'b0;
            data_be  <= 4'd0;
          end
          if (acked && load_q) result <= load_val;
          if (tmo) begin
            timed_out <= 1'b1;
          end else if (!acked) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // Pipeline-facing outputs: pass-through, stall, write-back and error flags.
  always_comb begin
    stallreq       = 1'b0;
    wreg_write_o   = 1'b0;
    wreg_addr_o    = 5'd0;
    wreg_data_o    = 32'd0;
    addr_err_load  = 1'b0;
    addr_err_store = 1'b0;
    bus_err        = 1'b0;
    bad_vaddr      = 32'd0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wreg_write_o = wreg_write_i & ~flush;
            wreg_addr_o  = wreg_addr_i;
            wreg_data_o  = wreg_data_i;
          end else if (misaligned) begin
            if (!flush) begin
              addr_err_load  = is_load;
              addr_err_store = is_store;
              bad_vaddr      = mem_oper_addr_i;
            end
          end else if (!flush) begin
            stallreq = 1'b1;
          end
        end
        BUSY: begin
          stallreq = 1'b1;
        end
        DONE: begin
          wreg_addr_o = wreg_addr_i;
          wreg_data_o = result;
          if (!flush) begin
            if (timed_out) begin
              bus_err   = 1'b1;
              bad_vaddr = mem_oper_addr_i;
            end else if (load_q) begin
              wreg_write_o = wreg_write_i;
            end
          end
        end
        default: begin
          stallreq = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
// tb_mem_access: self-checking bench for mem_access. A transaction-level
// model predicts every cycle of each instruction; one compare process checks
// the DUT on the falling edge. Directed cases first, then random traffic.

module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  Oper_t       oper_i;
  logic [31:0] mem_oper_addr_i;
  logic [31:0] mem_oper_data_i;
  logic        wreg_write_i;
  logic [4:0]  wreg_addr_i;
  logic [31:0] wreg_data_i;
  logic        flush;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        wreg_write_o;
  logic [4:0]  wreg_addr_o;
  logic [31:0] wreg_data_o;
  logic        stallreq;
  logic        addr_err_load;
  logic        addr_err_store;
  logic        bus_err;
  logic [31:0] bad_vaddr;

  mem_access #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .oper_i(oper_i),
    .mem_oper_addr_i(mem_oper_addr_i), .mem_oper_data_i(mem_oper_data_i),
    .wreg_write_i(wreg_write_i), .wreg_addr_i(wreg_addr_i), .wreg_data_i(wreg_data_i),
    .flush(flush), .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_ack(data_ack),
    .data_rdata(data_rdata), .wreg_write_o(wreg_write_o), .wreg_addr_o(wreg_addr_o),
    .wreg_data_o(wreg_data_o), .stallreq(stallreq), .addr_err_load(addr_err_load),
    .addr_err_store(addr_err_store), .bus_err(bus_err), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int stallCnt = 0;

  // Expected values for the current cycle, set by the stimulus task.
  bit          chkEn = 1'b0;
  logic        expStall, expReq, expWe, expWw, expAel, expAes, expBerr;
  logic [3:0]  expBe;
  logic [31:0] expAddr, expWdata, expWd, expBad;
  logic [4:0]  expWa;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isMemOp(Oper_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic bit isLoadOp(Oper_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic int sizeOf(Oper_t op);
    if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
    if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] beFn(Oper_t op, logic [31:0] addr);
    int sz = sizeOf(op);
    if (sz == 1) return 4'(1 << (addr % 4));
    if (sz == 2) return 4'(3 << (addr % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdataFn(Oper_t op, logic [31:0] d);
    int sz = sizeOf(op);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] loadFn(Oper_t op, logic [31:0] addr, logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (addr % 4));
    case (op)
      OP_LB:  begin v = v & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
      OP_LBU: v = v & 32'hFF;
      OP_LH:  begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
      OP_LHU: v = v & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearExp();
    expStall = 1'b0; expReq = 1'b0; expWe = 1'b0; expWw = 1'b0;
    expAel = 1'b0; expAes = 1'b0; expBerr = 1'b0; expBe = 4'd0;
    expAddr = 32'd0; expWdata = 32'd0; expWd = 32'd0; expBad = 32'd0; expWa = 5'd0;
  endtask

  // Drive one instruction through MEM. ackDelay = BUSY cycles before the ack
  // cycle; flushAt = cycle index of a flush pulse (0 = IDLE, 1.. = BUSY, then DONE).
  task automatic applyStimulus(input Oper_t op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                               input int ackDelay, input int flushAt, input logic [31:0] rdata);
    bit mem, ld, mis, gotAck, tmo, squashed, fin;
    int k;
    mem = isMemOp(op);
    ld  = isLoadOp(op);
    mis = mem && ((addr % sizeOf(op)) != 0);
    oper_i = op; mem_oper_addr_i = addr; mem_oper_data_i = sdata;
    wreg_write_i = ww; wreg_addr_i = wa; wreg_data_i = wd;
    flush = (flushAt == 0);
    data_ack = 1'($urandom_range(0, 1));
    data_rdata = $urandom;
    clearExp();
    chkEn = 1'b1;
    if (!mem) begin
      if (!flush) begin expWw = ww; expWa = wa; expWd = wd; end
    end else if (mis) begin
      if (!flush) begin expAel = ld; expAes = !ld; expBad = addr; end
    end else if (!flush) begin
      expStall = 1'b1;
    end
    tick();
    if (!mem || mis || flushAt == 0) begin
      flush = 1'b0;
      return;
    end
    squashed = 1'b0; tmo = 1'b0; k = 0; fin = 1'b0;
    while (!fin) begin
      k++;
      flush = (flushAt == k);
      if (flush) squashed = 1'b1;
      gotAck = (k == ackDelay + 1);
      tmo = !gotAck && (k == TO);
      data_ack = gotAck;
      data_rdata = gotAck ? rdata : $urandom;
      clearExp();
      expStall = 1'b1; expReq = 1'b1; expWe = !ld;
      expBe = beFn(op, addr); expAddr = addr & 32'hFFFF_FFFC; expWdata = wdataFn(op, sdata);
      tick();
      fin = gotAck || tmo;
    end
    data_ack = 1'b0;
    flush = 1'b0;
    if (squashed) return;
    flush = (flushAt == k + 1);
    data_ack = 1'($urandom_range(0, 1));
    data_rdata = $urandom;
    clearExp();
    if (!flush) begin
      if (tmo) begin
        expBerr = 1'b1; expBad = addr;
      end else if (ld) begin
        expWw = ww; expWa = wa; expWd = loadFn(op, addr, rdata);
      end
    end
    tick();
    flush = 1'b0;
  endtask

  // Single compare process: every enabled cycle, checked on the falling edge.
  always @(negedge clk) begin
    if (stallreq === 1'b1) stallCnt++;
    if (chkEn) begin
      checkOutput("stallreq", 32'(stallreq), 32'(expStall));
      checkOutput("data_req", 32'(data_req), 32'(expReq));
      checkOutput("addr_err_load", 32'(addr_err_load), 32'(expAel));
      checkOutput("addr_err_store", 32'(addr_err_store), 32'(expAes));
      checkOutput("bus_err", 32'(bus_err), 32'(expBerr));
      checkOutput("bad_vaddr", bad_vaddr, expBad);
      checkOutput("wreg_write_o", 32'(wreg_write_o), 32'(expWw));
      if (expReq) begin
        checkOutput("data_we", 32'(data_we), 32'(expWe));
        checkOutput("data_be", 32'(data_be), 32'(expBe));
        checkOutput("data_addr", data_addr, expAddr);
        if (expWe) checkOutput("data_wdata", data_wdata, expWdata);
      end
      if (expWw) begin
        checkOutput("wreg_addr_o", 32'(wreg_addr_o), 32'(expWa));
        checkOutput("wreg_data_o", wreg_data_o, expWd);
      end
    end
  end

  initial begin
    // Reset with a live ALU op on the inputs: outputs must still read 0.
    rst = 1'b1; oper_i = OP_ALU; mem_oper_addr_i = 32'h0; mem_oper_data_i = 32'h0;
    wreg_write_i = 1'b1; wreg_addr_i = 5'd7; wreg_data_i = 32'h1234; flush = 1'b0;
    data_ack = 1'b0; data_rdata = 32'h0;
    tick(); tick();
    checkOutput("rst_data_req", 32'(data_req), 32'd0);
    checkOutput("rst_stallreq", 32'(stallreq), 32'd0);
    checkOutput("rst_wreg_write_o", 32'(wreg_write_o), 32'd0);
    checkOutput("rst_wreg_data_o", wreg_data_o, 32'd0);
    checkOutput("rst_bad_vaddr", bad_vaddr, 32'd0);
    rst = 1'b0;

    // Literal pins on the model itself.
    checkOutput("pin_lb", loadFn(OP_LB, 32'h1003, 32'h8011_2233), 32'hFFFF_FF80);
    checkOutput("pin_lbu", loadFn(OP_LBU, 32'h1003, 32'h8011_2233), 32'h0000_0080);
    checkOutput("pin_sh_wdata", wdataFn(OP_SH, 32'h0000_ABCD), 32'hABCD_ABCD);
    checkOutput("pin_sh_be", 32'(beFn(OP_SH, 32'h2002)), 32'hC);
    checkOutput("pin_lb_be", 32'(beFn(OP_LB, 32'h1003)), 32'h8);

    // Directed cases.
    $display("[TB] directed cases");
    applyStimulus(OP_ALU, 32'h0, 32'h0, 1'b1, 5'd3, 32'hCAFE_0001, 0 + 9, -1, 32'h0);
    stallCnt = 0;
    applyStimulus(OP_LW, 32'h1000, 32'h0, 1'b1, 5'd4, 32'h0, 1, -1, 32'hDEAD_BEEF);
    checkOutput("lw_stall_cycles", 32'(stallCnt), 32'd3);
    applyStimulus(OP_LB,  32'h1003, 32'h0, 1'b1, 5'd5, 32'h0, 0, -1, 32'h8011_2233);
    applyStimulus(OP_LBU, 32'h1003, 32'h0, 1'b1, 5'd6, 32'h0, 0, -1, 32'h8011_2233);
    applyStimulus(OP_SH,  32'h2002, 32'h0000_ABCD, 1'b1, 5'd8, 32'h0, 0, -1, 32'h0);
    applyStimulus(OP_LW,  32'h1002, 32'h0, 1'b1, 5'd9, 32'h0, 0, -1, 32'h0);
    applyStimulus(OP_SW,  32'h1001, 32'h5555_AAAA, 1'b0, 5'd0, 32'h0, 0, -1, 32'h0);
    applyStimulus(OP_LH,  32'h1002, 32'h0, 1'b1, 5'd10, 32'h0, 2, 1, 32'h1234_5678);
    applyStimulus(OP_LW,  32'h4000, 32'h0, 1'b1, 5'd11, 32'h0, 100, -1, 32'h0);
    applyStimulus(OP_LHU, 32'h4002, 32'h0, 1'b1, 5'd12, 32'h0, 0, 0, 32'hFFFF_0000);
    applyStimulus(OP_LHU, 32'h4002, 32'h0, 1'b1, 5'd12, 32'h0, 0, 2, 32'hFFFF_0000);
    applyStimulus(OP_ALU, 32'h0, 32'h0, 1'b1, 5'd13, 32'h0BAD_F00D, 0, 0, 32'h0);

    // Async reset in BUSY must drop the request in the same cycle.
    chkEn = 1'b0;
    oper_i = OP_LW; mem_oper_addr_i = 32'h3000; flush = 1'b0; data_ack = 1'b0;
    tick();
    checkOutput("busy_req_before_rst", 32'(data_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_in_busy_req", 32'(data_req), 32'd0);
    checkOutput("rst_in_busy_be", 32'(data_be), 32'd0);
    checkOutput("rst_in_busy_stall", 32'(stallreq), 32'd0);
    tick();
    rst = 1'b0;
    oper_i = OP_NOP; wreg_write_i = 1'b0;
    tick();

    // Random traffic.
    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      int r;
      int fa;
      r  = $urandom_range(0, 15);
      fa = (r < 11) ? -1 : r - 11;
      applyStimulus(Oper_t'($urandom_range(0, 9)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                    $urandom_range(0, 5), fa, $urandom);
    end

    chkEn = 1'b0;
    oper_i = OP_NOP;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
